// File: rtl/adder_tree_pkg.sv
// Shared types and width helpers for the CSA adder tree and its loader.
// Keeps word/frame widths in one place so both sides agree.
package adder_tree_pkg;

    localparam int TREE_DATA_W = 3;
    localparam int TREE_DATA_N = 9;

    typedef logic [TREE_DATA_W-1:0] word_t;
    // Word 0 sits in the most significant position of the packed frame.
    typedef logic [0:TREE_DATA_N-1][TREE_DATA_W-1:0] frame_t;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } loader_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adder_tree_loader_oslot.sv
// Registered valid/ready output slot holding one frame and its word count.
// The parent only asserts load when the slot is empty or draining this cycle.
module adder_tree_loader_oslot
    import adder_tree_pkg::*;
#(
    parameter int DATA_W = TREE_DATA_W,
    parameter int DATA_N = TREE_DATA_N,
    parameter int CNT_W  = cnt_w(TREE_DATA_N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [DATA_N*DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]         load_count,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [DATA_N*DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]         o_count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_count <= '0;
        end else if (load) begin
            // Covers drain-and-reload in the same cycle: valid stays high.
            o_valid <= 1'b1;
            o_data  <= load_data;
            o_count <= load_count;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/adder_tree_loader.sv
// Serial-to-frame loader feeding the CSA adder tree through a registered slot.
// Optional partial frames via i_last when ADDER_TREE_LOADER_LAST_EN is defined.
module adder_tree_loader
    import adder_tree_pkg::*;
#(
    parameter  int DATA_W = TREE_DATA_W,
    parameter  int DATA_N = TREE_DATA_N,
    localparam int CNT_W  = cnt_w(DATA_N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DATA_W-1:0]        i_data,
`ifdef ADDER_TREE_LOADER_LAST_EN
    input  logic                     i_last,
`endif
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DATA_N*DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]         o_count
);

    localparam int IDX_W = $clog2(DATA_N);

    typedef logic [0:DATA_N-1][DATA_W-1:0] fr_t;

    loader_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    fr_t              buf_q;
    fr_t              wr_buf;
    fr_t              load_frame;
    logic [CNT_W-1:0] load_cnt;
    logic             rdy_q;
    logic             accept;
    logic             last_w;
    logic             frame_done;
    logic             slot_free;
    logic             load;

`ifdef ADDER_TREE_LOADER_LAST_EN
    assign last_w = i_last;
`else
    assign last_w = 1'b0;
`endif

    assign o_ready    = rdy_q && (state_q == FILL);
    assign accept     = i_valid && o_ready;
    assign frame_done = accept && ((idx_q == IDX_W'(DATA_N - 1)) || last_w);
    assign slot_free  = !o_valid || i_ready;

    // In FILL idx points at the incoming word; in WAIT it points at the last
    // stored word. Either way the frame holds idx+1 real words.
    assign load_cnt = CNT_W'(idx_q) + CNT_W'(1);

    always_comb begin
        wr_buf = buf_q;
        if (accept) wr_buf[idx_q] = i_data;
    end

    // Slots past the real words read as zero so a partial frame sums correctly.
    always_comb begin
        load_frame = '0;
        for (int j = 0; j < DATA_N; j++) begin
            if (CNT_W'(j) < load_cnt) load_frame[j] = wr_buf[j];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            FILL: begin
                if (frame_done) begin
                    if (slot_free) begin
                        load  = 1'b1;
                        idx_d = '0;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (accept) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WAIT: begin
                if (slot_free) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rdy_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else if (accept) begin
            buf_q[idx_q] <= i_data;
        end
    end

    adder_tree_loader_oslot #(
        .DATA_W (DATA_W),
        .DATA_N (DATA_N),
        .CNT_W  (CNT_W)
    ) u_oslot (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_frame),
        .load_count (load_cnt),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_count    (o_count)
    );

endmodule
